// File: rtl/msb_pe_pkg.sv
// Shared types and helpers for the MSB priority-encoder decode stream.
// Used by msb_pe_decode_stream and skid_buf_2.
package msb_pe_pkg;

    localparam int unsigned ERR_W_DEF = 8;

    // Occupancy of the two-entry skid stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Encoded index width; also holds the encoder's "no bit set" code N.
    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Generic 2-entry valid/ready skid buffer.
// in_ready is a register, so there is no combinational path from out_ready.
// A beat that arrives while the output register is stalled parks in the skid entry.
module skid_buf_2
    import msb_pe_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    state_t       state;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Occupancy FSM with registered ready/valid and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= TWO;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/msb_pe_decode_stream.sv
// Streaming inverse of the N-bit MSB priority encoder: index in, one-hot out.
// Out-of-range indices (>= N) give a zero vector, raise out_err and bump a
// saturating error counter.
// Optional: define MSB_PE_DECODE_THERMO_EN to add out_thermo (bits 0..idx set).
module msb_pe_decode_stream
    import msb_pe_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = idx_width(N),
    parameter int unsigned ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_vec,
    output logic             out_err,
`ifdef MSB_PE_DECODE_THERMO_EN
    output logic [N-1:0]     out_thermo,
`endif
    output logic [ERR_W-1:0] err_cnt
);

`ifdef MSB_PE_DECODE_THERMO_EN
    localparam int unsigned PW = 2 * N + 1;
`else
    localparam int unsigned PW = N + 1;
`endif

    logic [N-1:0]  dec_vec;
    logic          dec_err;
`ifdef MSB_PE_DECODE_THERMO_EN
    logic [N-1:0]  dec_thermo;
`endif
    logic [PW-1:0] in_data;
    logic [PW-1:0] out_data;

    // Decode: one-hot at idx; an index with no matching bit is an error.
    always_comb begin
        dec_vec = '0;
        for (int i = 0; i < N; i++) begin
            dec_vec[i] = (in_idx == IDX_W'(i));
        end
        dec_err = ~(|dec_vec);
`ifdef MSB_PE_DECODE_THERMO_EN
        dec_thermo = '0;
        for (int i = 0; i < N; i++) begin
            dec_thermo[i] = (in_idx >= IDX_W'(i)) & ~dec_err;
        end
`endif
    end

`ifdef MSB_PE_DECODE_THERMO_EN
    assign in_data    = {dec_err, dec_thermo, dec_vec};
    assign out_thermo = out_data[2*N-1:N];
`else
    assign in_data    = {dec_err, dec_vec};
`endif
    assign out_vec = out_data[N-1:0];
    assign out_err = out_data[PW-1];

    skid_buf_2 #(
        .W (PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Saturating count of accepted out-of-range indices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (in_valid && in_ready && dec_err && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule
